// File: rtl/dec_ascii_pkg.sv
// ---------------------------------------------------------------------------
// dec_ascii_pkg
// Shared types and constants for the binary-to-ASCII decimal converter.
//   state_t    : converter FSM states (IDLE, CONV, DONE)
//   NUM_W      : width of the binary input value
//   NDIG       : number of decimal digits produced
//   ITER       : double-dabble iterations (one per input bit)
//   ASCII_ZERO : ASCII code of the character '0'
// ---------------------------------------------------------------------------
package dec_ascii_pkg;

    localparam int unsigned NUM_W      = 32;
    localparam int unsigned NDIG       = 10;
    localparam int unsigned ITER       = 32;
    localparam int unsigned CNT_W      = $clog2(ITER);
    localparam logic [7:0]  ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : dec_ascii_pkg

// File: rtl/dec_ascii_conv_if.sv
// ---------------------------------------------------------------------------
// dec_ascii_conv_if
// Request/result bundle of the decimal converter.
//   load        : start request, NUM sampled on the accepting edge
//   NUM         : unsigned binary value to convert
//   CHAR0..CHAR9: ASCII decimal digits, CHAR0 least significant
//   busy        : conversion in progress
//   done        : CHAR0..CHAR9 hold a completed result
// Modports: master (requester side), slave (converter side).
// ---------------------------------------------------------------------------
interface dec_ascii_conv_if;
    import dec_ascii_pkg::*;

    logic             load;
    logic [NUM_W-1:0] NUM;
    logic [7:0]       CHAR0, CHAR1, CHAR2, CHAR3, CHAR4;
    logic [7:0]       CHAR5, CHAR6, CHAR7, CHAR8, CHAR9;
    logic             busy;
    logic             done;

    modport master (
        output load, NUM,
        input  CHAR0, CHAR1, CHAR2, CHAR3, CHAR4,
        input  CHAR5, CHAR6, CHAR7, CHAR8, CHAR9,
        input  busy, done
    );

    modport slave (
        input  load, NUM,
        output CHAR0, CHAR1, CHAR2, CHAR3, CHAR4,
        output CHAR5, CHAR6, CHAR7, CHAR8, CHAR9,
        output busy, done
    );

endinterface : dec_ascii_conv_if

// File: rtl/dec_ascii_conv_bcd_adj3.sv
// ---------------------------------------------------------------------------
// bcd_adj3
// Double-dabble nibble correction: adds 3 to a BCD digit that is >= 5 so
// that the following left shift carries correctly into the next digit.
//   din  : BCD digit before correction
//   dout : corrected digit
// ---------------------------------------------------------------------------
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule : bcd_adj3

// File: rtl/dec_ascii_conv.sv
// ---------------------------------------------------------------------------
// dec_ascii_conv
// Sequential binary-to-ASCII decimal converter (shift-and-add-3). A load in
// IDLE or DONE captures NUM; 32 CONV cycles later the ten ASCII digits are
// registered, done rises and busy falls on the same edge.
//   clk        : conversion clock
//   reset      : asynchronous, active-high reset
//   bus        : dec_ascii_conv_if.slave (load, NUM, CHAR0..CHAR9, busy, done)
//   BLANK_CHAR : character driven on blanked leading-zero digits
// Build option: define DEC_LZB_EN to blank leading zeros with BLANK_CHAR
// (CHAR0 always stays a digit).
// ---------------------------------------------------------------------------
module dec_ascii_conv
    import dec_ascii_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                clk,
    input  logic                reset,
    dec_ascii_conv_if.slave     bus
);

`ifdef DEC_LZB_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   bin_q, bin_next;
    logic [4*NDIG-1:0]  bcd_q, bcd_adj, bcd_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         char_q    [NDIG];
    logic [7:0]         char_next [NDIG];
    logic               last_iter;
    logic               seen_nz;
    logic [3:0]         digit;
    // Top digit never reaches 8 for a 32-bit input, so the shifted-out bit
    // is always zero.
    logic               unused_msb;

    // ------------------------------------------------------------------
    // Per-digit add-3 correction ahead of the shift
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (bcd_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign {unused_msb, bcd_next, bin_next} = {bcd_adj, bin_q, 1'b0};

    assign last_iter = (state_q == CONV) && (cnt_q == CNT_W'(ITER - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: state elements use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    // NOTE: defaults assigned first so no path leaves a signal unassigned
    // and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (bus.load) state_d = CONV;
            CONV:       if (last_iter) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result formatting from the final adjusted-and-shifted BCD value,
    // scanning from the most significant digit to track leading zeros.
    // ------------------------------------------------------------------
    always_comb begin
        char_next = '{default: ASCII_ZERO};
        seen_nz   = 1'b0;
        digit     = 4'd0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            digit = bcd_next[4*i +: 4];
            if (digit != 4'd0) seen_nz = 1'b1;
            if (LZB_EN && !seen_nz && (i != 0)) char_next[i] = BLANK_CHAR;
            else                                char_next[i] = ASCII_ZERO + {4'd0, digit};
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, iteration counter and result registers
    // ------------------------------------------------------------------
    // NOTE: the result registers are reset too, so the outputs read as
    // "0000000000" after reset and an aborted run never leaks a partial value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NDIG; i++) char_q[i] <= ASCII_ZERO;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.load) begin
                        bin_q <= bus.NUM;
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CONV: begin
                    bin_q <= bin_next;
                    bcd_q <= bcd_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) char_q <= char_next;
                end
                default: ;
            endcase
        end
    end

    // Status decoded from the state register: mutually exclusive by design.
    assign bus.busy = (state_q == CONV);
    assign bus.done = (state_q == DONE);

    assign bus.CHAR0 = char_q[0];
    assign bus.CHAR1 = char_q[1];
    assign bus.CHAR2 = char_q[2];
    assign bus.CHAR3 = char_q[3];
    assign bus.CHAR4 = char_q[4];
    assign bus.CHAR5 = char_q[5];
    assign bus.CHAR6 = char_q[6];
    assign bus.CHAR7 = char_q[7];
    assign bus.CHAR8 = char_q[8];
    assign bus.CHAR9 = char_q[9];

endmodule : dec_ascii_conv

// File: tb/tb_dec_ascii_conv.sv
// ---------------------------------------------------------------------------
// tb_dec_ascii_conv
// Directed self-checking bench for dec_ascii_conv. Expected digit strings are
// hand-written ASCII constants (CHAR9 is the leftmost character).
// ---------------------------------------------------------------------------
module tb_dec_ascii_conv;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dec_ascii_conv_if bus ();

    dec_ascii_conv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] get_chars();
        return {bus.CHAR9, bus.CHAR8, bus.CHAR7, bus.CHAR6, bus.CHAR5,
                bus.CHAR4, bus.CHAR3, bus.CHAR2, bus.CHAR1, bus.CHAR0};
    endfunction

    // Present a one-cycle load; returns at the negedge after the accepting edge.
    task automatic do_load(input logic [31:0] num);
        @(negedge clk);
        bus.load = 1'b1;
        bus.NUM  = num;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Runs a conversion already loaded: expects busy for exactly 32 samples
    // with outputs frozen at prev, then done with the expected string.
    task automatic run_conv(input string name, input logic [79:0] prev,
                            input logic [79:0] exp);
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy/done cycle %0d: got busy=%b done=%b, want busy=1 done=0",
                         name, k, bus.busy, bus.done);
            end
            n_checks++;
            if (get_chars() !== prev) begin
                n_fail++;
                $display("FAIL %s chars held cycle %0d: got %h, want %h", name, k, get_chars(), prev);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s completion: got busy=%b done=%b, want busy=0 done=1",
                     name, bus.busy, bus.done);
        end
        n_checks++;
        if (get_chars() !== exp) begin
            n_fail++;
            $display("FAIL %s result: got %h, want %h", name, get_chars(), exp);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.NUM  = '0;
        #12;
        n_checks++;
        if (get_chars() !== "0000000000") begin
            n_fail++;
            $display("FAIL reset chars: got %h, want %h", get_chars(), 80'("0000000000"));
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset flags: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || get_chars() !== "0000000000") begin
            n_fail++;
            $display("FAIL idle after reset: got busy=%b done=%b chars=%h, want 0 0 %h",
                     bus.busy, bus.done, get_chars(), 80'("0000000000"));
        end
    endtask

    task automatic test_zero();
        logic [79:0] exp;
`ifdef DEC_LZB_EN
        exp = {{9{8'h20}}, 8'h30};
`else
        exp = "0000000000";
`endif
        do_load(32'd0);
        run_conv("zero", "0000000000", exp);
    endtask

    task automatic test_max();
        logic [79:0] prev;
        prev = get_chars();
        do_load(32'hFFFF_FFFF);
        run_conv("max", prev, "4294967295");
        // done must persist in DONE without a new load
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || get_chars() !== "4294967295") begin
            n_fail++;
            $display("FAIL max hold: got done=%b chars=%h, want 1 %h",
                     bus.done, get_chars(), 80'("4294967295"));
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] prev;
        prev = get_chars();
        do_load(32'd1234567890);
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                bus.load = 1'b1;
                bus.NUM  = 32'd5;
            end else begin
                bus.load = 1'b0;
            end
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b busy/done cycle %0d: got busy=%b done=%b, want 1 0",
                         k, bus.busy, bus.done);
            end
            n_checks++;
            if (get_chars() !== prev) begin
                n_fail++;
                $display("FAIL b2b chars held cycle %0d: got %h, want %h", k, get_chars(), prev);
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b completion: got busy=%b done=%b, want 0 1", bus.busy, bus.done);
        end
        n_checks++;
        if (get_chars() !== "1234567890") begin
            n_fail++;
            $display("FAIL b2b result: got %h, want %h", get_chars(), 80'("1234567890"));
        end
    endtask

    task automatic test_reset_abort();
        logic [79:0] exp;
`ifdef DEC_LZB_EN
        exp = {{9{8'h20}}, 8'h37};
`else
        exp = "0000000007";
`endif
        do_load(32'd987654321);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (get_chars() !== "0000000000" || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort reset: got busy=%b done=%b chars=%h, want 0 0 %h",
                     bus.busy, bus.done, get_chars(), 80'("0000000000"));
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        do_load(32'd7);
        run_conv("after_abort", "0000000000", exp);
    endtask

    task automatic test_lzb();
        logic [79:0] prev;
        logic [79:0] exp;
`ifdef DEC_LZB_EN
        exp = {{8{8'h20}}, 8'h34, 8'h32};
`else
        exp = "0000000042";
`endif
        prev = get_chars();
        do_load(32'd42);
        run_conv("lzb42", prev, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_zero();
        test_max();
        test_back_to_back();
        test_reset_abort();
        test_lzb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_dec_ascii_conv

// File: doc/dec_ascii_conv.md
DEC_ASCII_CONV -- requirements
Module: dec_ascii_conv

Interface
REQ-001 The block SHALL have parameter BLANK_CHAR, default 8'h20, the ASCII code driven on blanked leading-zero digits (used only with DEC_LZB_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: conversion clock (SD card clock domain).
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1 bit: start request; NUM is sampled on the accepting edge.
REQ-005 The block SHALL have port NUM, input, 32 bits: unsigned binary value to convert.
REQ-006 The block SHALL have ports CHAR0..CHAR9, output, 8 bits each: ASCII decimal digits, with CHAR0 the least significant.
REQ-007 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-008 The block SHALL have port done, output, 1 bit: CHAR0..CHAR9 hold a completed result.

Function
REQ-009 The block SHALL implement FSM states IDLE, CONV and DONE.
REQ-010 In IDLE or DONE, load=1 at a clk edge SHALL capture NUM into a 32-bit shift register, clear a 40-bit BCD register and a 5-bit iteration counter, clear done, set busy and enter CONV.
REQ-011 Each CONV cycle SHALL first add 3 to every BCD nibble that is >=5, then left-shift {BCD, binary} by one bit, then increment the counter.
REQ-012 On the 32nd CONV edge (counter==31), the block SHALL register the adjusted-and-shifted BCD nibble i as 8'h30+nibble onto CHARi, set done, clear busy and enter DONE, all on that same edge.
REQ-013 Latency SHALL be exactly 32 clk edges from the load-accepting edge to the edge that raises done.
REQ-014 load SHALL be ignored while busy=1; the conversion in progress SHALL complete with its originally captured NUM.
REQ-015 CHAR0..CHAR9 SHALL hold their previous values throughout CONV and change only on the completion edge.
REQ-016 done SHALL remain 1 in DONE until the next accepted load; a load in DONE SHALL clear done on the accepting edge.
REQ-017 busy and done SHALL never both be 1.
REQ-018 NUM=32'hFFFFFFFF SHALL convert without overflow to "4294967295"; the BCD register SHALL be 40 bits (10 nibbles).

Reset
REQ-019 On reset=1, the block SHALL asynchronously force: state IDLE, CHAR0..CHAR9=8'h30, busy=0, done=0, counter=0, shift registers=0.
REQ-020 A reset during CONV SHALL abort the conversion, and the outputs SHALL take the reset values with no partial result ever presented.

Configuration
REQ-021 With macro DEC_LZB_EN defined, on the completion edge every digit above the most significant non-zero digit SHALL be driven as BLANK_CHAR; CHAR0 SHALL always be a digit, so NUM=0 gives CHAR0=8'h30.
REQ-022 Without DEC_LZB_EN, all ten CHAR outputs SHALL always be ASCII digits, including leading zeros.

Structure
REQ-023 Package dec_ascii_pkg SHALL hold the state enum typedef (IDLE/CONV/DONE) and the constants NUM_W=32, NDIG=10, ITER=32 and ASCII_ZERO=8'h30.
REQ-024 The design SHALL contain one sub-module, bcd_adj3 (combinational 4-bit add-3-if->=5 correction), instantiated NDIG times.

Verification
REQ-025 The bench SHALL check that after reset, CHAR0..CHAR9=8'h30, busy=0 and done=0.
REQ-026 The bench SHALL check that load with NUM=0 gives busy=1 for 32 cycles, then done=1 with all CHAR=8'h30.
REQ-027 The bench SHALL check that NUM=32'hFFFFFFFF gives CHAR9..CHAR0 = 34 32 39 34 39 36 37 32 39 35 (hex) after 32 edges.
REQ-028 The bench SHALL check that load NUM=1234567890, then load NUM=5 after 10 cycles, yields the second load ignored and the result "1234567890", with CHARs unchanged until the completion edge.
REQ-029 The bench SHALL check that reset asserted at CONV cycle 20 forces immediate reset values; a subsequent load NUM=7 then gives CHAR0=8'h37 after 32 edges.
REQ-030 The bench SHALL check that, with DEC_LZB_EN defined, NUM=42 gives CHAR0=8'h32, CHAR1=8'h34 and CHAR2..CHAR9=8'h20; without the macro, CHAR2..CHAR9=8'h30.
